// File: rtl/riscv_decode_pipe.sv
// riscv_decode_pipe: decode stage with register file, W->D bypass, load-use bubble, ID/EX register
//   in : i_clk, i_rstn (sync active-low), D-stage instr/pc/pc+4/ctrl/imm/valid, W-stage write port,
//        i_stall_e / i_flush_e from the hazard unit
//   out: E-stage valid/ctrl/reg data/reg addresses/pc/pc+4/imm, o_stall_d, o_bubble_cnt
module riscv_decode_pipe #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int CTRL_W   = 16,
  parameter  int LOAD_BIT = 0,
  parameter  int CNT_W    = 16,
  localparam int RA_W     = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid_d,
  input  logic [31:0]       i_instr_d,
  input  logic [XLEN-1:0]   i_pc_d,
  input  logic [XLEN-1:0]   i_pc_plus_4d,
  input  logic [CTRL_W-1:0] i_ctrl_d,
  input  logic [XLEN-1:0]   i_imm_ext_d,
  input  logic [RA_W-1:0]   i_rd_w,
  input  logic [XLEN-1:0]   i_result_w,
  input  logic              i_reg_write_w,
  input  logic              i_stall_e,
  input  logic              i_flush_e,
  output logic              o_valid_e,
  output logic [CTRL_W-1:0] o_ctrl_e,
  output logic [XLEN-1:0]   o_rd1_e,
  output logic [XLEN-1:0]   o_rd2_e,
  output logic [RA_W-1:0]   o_rs1_e,
  output logic [RA_W-1:0]   o_rs2_e,
  output logic [RA_W-1:0]   o_rd_e,
  output logic [XLEN-1:0]   o_pc_e,
  output logic [XLEN-1:0]   o_pc_plus_4e,
  output logic [XLEN-1:0]   o_imm_e,
  output logic              o_stall_d,
  output logic [CNT_W-1:0]  o_bubble_cnt
);
  logic [XLEN-1:0]   rf_q [NREG];
  logic [RA_W-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0]   rd1, rd2;
  logic              lu_hazard;
  logic              unused_instr;
  logic              valid_e_q, valid_e_d;
  logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
  logic [XLEN-1:0]   rd1_e_q, rd1_e_d, rd2_e_q, rd2_e_d;
  logic [RA_W-1:0]   rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;
  logic [XLEN-1:0]   pc_e_q, pc_e_d, pc4_e_q, pc4_e_d, imm_e_q, imm_e_d;
  logic [CNT_W-1:0]  bub_q, bub_d;
  assign unused_instr = ^i_instr_d;
  assign rs1 = i_instr_d[15 +: RA_W];
  assign rs2 = i_instr_d[20 +: RA_W];
  assign rd  = i_instr_d[7 +: RA_W];
  // write-first: a same-cycle W write to the register being read wins over the array
  assign rd1 = rs1 == '0 ? '0 : (i_reg_write_w && i_rd_w == rs1) ? i_result_w : rf_q[rs1];
  assign rd2 = rs2 == '0 ? '0 : (i_reg_write_w && i_rd_w == rs2) ? i_result_w : rf_q[rs2];
  // both source fields compared regardless of format; a false stall is only a lost cycle
  assign lu_hazard = valid_e_q && ctrl_e_q[LOAD_BIT] && rd_e_q != '0 && i_valid_d &&
                     (rd_e_q == rs1 || rd_e_q == rs2);
  assign o_stall_d = lu_hazard | i_stall_e;
  always_ff @(posedge i_clk) begin
    if (!i_rstn)
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    else if (i_reg_write_w && i_rd_w != '0)
      rf_q[i_rd_w] <= i_result_w;
  end
  always_comb begin
    valid_e_d = valid_e_q;
    ctrl_e_d  = ctrl_e_q;
    rd1_e_d   = rd1_e_q;
    rd2_e_d   = rd2_e_q;
    rs1_e_d   = rs1_e_q;
    rs2_e_d   = rs2_e_q;
    rd_e_d    = rd_e_q;
    pc_e_d    = pc_e_q;
    pc4_e_d   = pc4_e_q;
    imm_e_d   = imm_e_q;
    bub_d     = bub_q;
    if (i_flush_e) begin
      valid_e_d = 1'b0;
      ctrl_e_d  = '0;
    end else if (i_stall_e) begin
      valid_e_d = valid_e_q;
    end else if (lu_hazard) begin
      valid_e_d = 1'b0;
      ctrl_e_d  = '0;
      rd1_e_d   = '0;
      rd2_e_d   = '0;
      rs1_e_d   = '0;
      rs2_e_d   = '0;
      rd_e_d    = '0;
      pc_e_d    = '0;
      pc4_e_d   = '0;
      imm_e_d   = '0;
      bub_d     = bub_q == '1 ? bub_q : bub_q + 1'b1;
    end else begin
      valid_e_d = i_valid_d;
      ctrl_e_d  = i_valid_d ? i_ctrl_d : '0;
      rd1_e_d   = rd1;
      rd2_e_d   = rd2;
      rs1_e_d   = rs1;
      rs2_e_d   = rs2;
      rd_e_d    = rd;
      pc_e_d    = i_pc_d;
      pc4_e_d   = i_pc_plus_4d;
      imm_e_d   = i_imm_ext_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid_e_q <= 1'b0;
      ctrl_e_q  <= '0;
      rd1_e_q   <= '0;
      rd2_e_q   <= '0;
      rs1_e_q   <= '0;
      rs2_e_q   <= '0;
      rd_e_q    <= '0;
      pc_e_q    <= '0;
      pc4_e_q   <= '0;
      imm_e_q   <= '0;
      bub_q     <= '0;
    end else begin
      valid_e_q <= valid_e_d;
      ctrl_e_q  <= ctrl_e_d;
      rd1_e_q   <= rd1_e_d;
      rd2_e_q   <= rd2_e_d;
      rs1_e_q   <= rs1_e_d;
      rs2_e_q   <= rs2_e_d;
      rd_e_q    <= rd_e_d;
      pc_e_q    <= pc_e_d;
      pc4_e_q   <= pc4_e_d;
      imm_e_q   <= imm_e_d;
      bub_q     <= bub_d;
    end
  end
  assign o_valid_e    = valid_e_q;
  assign o_ctrl_e     = ctrl_e_q;
  assign o_rd1_e      = rd1_e_q;
  assign o_rd2_e      = rd2_e_q;
  assign o_rs1_e      = rs1_e_q;
  assign o_rs2_e      = rs2_e_q;
  assign o_rd_e       = rd_e_q;
  assign o_pc_e       = pc_e_q;
  assign o_pc_plus_4e = pc4_e_q;
  assign o_imm_e      = imm_e_q;
  assign o_bubble_cnt = bub_q;
endmodule

// File: tb/tb_riscv_decode_pipe.sv
// tb_riscv_decode_pipe: directed self-checking bench for riscv_decode_pipe (plus a CNT_W=2 copy for saturation)
module tb_riscv_decode_pipe;
  logic        clk = 1'b0;
  logic        rstn, valid_d, we_w, stall_e, flush_e;
  logic [31:0] instr, pc, pc4, imm, result_w;
  logic [15:0] ctrl;
  logic [4:0]  rd_w;
  logic        valid_e, stall_d;
  logic [15:0] ctrl_e, bub;
  logic [31:0] rd1_e, rd2_e, pc_e, pc4_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        s_valid_e, s_stall_d;
  logic [15:0] s_ctrl_e;
  logic [1:0]  s_bub;
  logic [31:0] s_rd1_e, s_rd2_e, s_pc_e, s_pc4_e, s_imm_e;
  logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
  int          checks = 0;
  int          passes = 0;
  int          exp_bub = 0;
  always #5 clk = ~clk;
  riscv_decode_pipe dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid_d(valid_d), .i_instr_d(instr), .i_pc_d(pc),
    .i_pc_plus_4d(pc4), .i_ctrl_d(ctrl), .i_imm_ext_d(imm), .i_rd_w(rd_w), .i_result_w(result_w),
    .i_reg_write_w(we_w), .i_stall_e(stall_e), .i_flush_e(flush_e), .o_valid_e(valid_e),
    .o_ctrl_e(ctrl_e), .o_rd1_e(rd1_e), .o_rd2_e(rd2_e), .o_rs1_e(rs1_e), .o_rs2_e(rs2_e),
    .o_rd_e(rd_e), .o_pc_e(pc_e), .o_pc_plus_4e(pc4_e), .o_imm_e(imm_e), .o_stall_d(stall_d),
    .o_bubble_cnt(bub)
  );
  riscv_decode_pipe #(.CNT_W(2)) sat (
    .i_clk(clk), .i_rstn(rstn), .i_valid_d(valid_d), .i_instr_d(instr), .i_pc_d(pc),
    .i_pc_plus_4d(pc4), .i_ctrl_d(ctrl), .i_imm_ext_d(imm), .i_rd_w(rd_w), .i_result_w(result_w),
    .i_reg_write_w(we_w), .i_stall_e(stall_e), .i_flush_e(flush_e), .o_valid_e(s_valid_e),
    .o_ctrl_e(s_ctrl_e), .o_rd1_e(s_rd1_e), .o_rd2_e(s_rd2_e), .o_rs1_e(s_rs1_e), .o_rs2_e(s_rs2_e),
    .o_rd_e(s_rd_e), .o_pc_e(s_pc_e), .o_pc_plus_4e(s_pc4_e), .o_imm_e(s_imm_e), .o_stall_d(s_stall_d),
    .o_bubble_cnt(s_bub)
  );
  function automatic logic [31:0] ins(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {7'h00, s2, s1, 3'h0, d, 7'h33};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic setd(input logic v, input logic [31:0] in, input logic [31:0] p, input logic [15:0] c);
    valid_d = v;
    instr   = in;
    pc      = p;
    pc4     = p + 32'd4;
    imm     = p ^ 32'h5A5A_0000;
    ctrl    = c;
  endtask
  initial begin
    rstn = 1'b0; valid_d = 1'b1; instr = $urandom; pc = $urandom; pc4 = $urandom;
    ctrl = 16'($urandom); imm = $urandom; rd_w = 5'($urandom); result_w = $urandom;
    we_w = 1'b1; stall_e = 1'($urandom); flush_e = 1'($urandom);
    tick;
    stall_e = 1'b0; flush_e = 1'b0; we_w = 1'b0;
    #1;
    chk("rst_valid", valid_e, 0);
    chk("rst_ctrl", ctrl_e, 0);
    chk("rst_rd1", rd1_e, 0);
    chk("rst_rd2", rd2_e, 0);
    chk("rst_rs1", rs1_e, 0);
    chk("rst_rs2", rs2_e, 0);
    chk("rst_rd", rd_e, 0);
    chk("rst_pc", pc_e, 0);
    chk("rst_pc4", pc4_e, 0);
    chk("rst_imm", imm_e, 0);
    chk("rst_stall_d", stall_d, 0);
    chk("rst_bub", bub, 0);
    chk("rst_sat_bub", s_bub, 0);
    rstn = 1'b1;
    for (int x = 1; x < 32; x++) begin
      setd(1'b1, ins(5'd0, 5'(x), 5'(x)), 32'h40, 16'h0000);
      tick;
      chk("zero_rd1", rd1_e, 0);
      chk("zero_rd2", rd2_e, 0);
    end
    chk("zero_rs1_addr", rs1_e, 31);
    we_w = 1'b1; rd_w = 5'd5; result_w = 32'hDEAD_BEEF;
    setd(1'b1, ins(5'd6, 5'd5, 5'd0), 32'h100, 16'h0008);
    tick;
    chk("byp_rd1", rd1_e, 32'hDEAD_BEEF);
    chk("byp_rd2", rd2_e, 0);
    chk("byp_valid", valid_e, 1);
    chk("byp_ctrl", ctrl_e, 16'h0008);
    chk("byp_rd", rd_e, 6);
    chk("byp_pc", pc_e, 32'h100);
    chk("byp_pc4", pc4_e, 32'h104);
    chk("byp_imm", imm_e, 32'h5A5A_0100);
    rd_w = 5'd7; result_w = 32'h0000_1234;
    setd(1'b1, ins(5'd6, 5'd5, 5'd8), 32'h104, 16'h0008);
    tick;
    chk("held_x5", rd1_e, 32'hDEAD_BEEF);
    chk("nobyp_x8", rd2_e, 0);
    rd_w = 5'd0; result_w = 32'h0000_0001;
    setd(1'b1, ins(5'd6, 5'd0, 5'd7), 32'h108, 16'h0008);
    tick;
    chk("x0_byp_rd1", rd1_e, 0);
    chk("x7_rd2", rd2_e, 32'h0000_1234);
    we_w = 1'b0;
    setd(1'b1, ins(5'd6, 5'd0, 5'd0), 32'h10C, 16'h0008);
    tick;
    chk("x0_after_wr", rd1_e, 0);
    setd(1'b1, ins(5'd3, 5'd1, 5'd0), 32'h200, 16'h0001);
    tick;
    setd(1'b1, ins(5'd4, 5'd3, 5'd1), 32'h204, 16'h0002);
    #1;
    chk("lu_stall_d", stall_d, 1);
    tick;
    exp_bub++;
    chk("lu_bubble_valid", valid_e, 0);
    chk("lu_bubble_ctrl", ctrl_e, 0);
    chk("lu_bubble_rd", rd_e, 0);
    chk("lu_bubble_pc", pc_e, 0);
    chk("lu_cnt", bub, exp_bub);
    chk("lu_stall_released", stall_d, 0);
    tick;
    chk("lu_add_valid", valid_e, 1);
    chk("lu_add_rd", rd_e, 4);
    chk("lu_add_rs1", rs1_e, 3);
    chk("lu_add_pc", pc_e, 32'h204);
    chk("lu_add_ctrl", ctrl_e, 16'h0002);
    setd(1'b1, ins(5'd3, 5'd1, 5'd0), 32'h208, 16'h0001);
    tick;
    setd(1'b0, ins(5'd4, 5'd3, 5'd3), 32'h20C, 16'h0002);
    #1;
    chk("lu_invalid_d_nostall", stall_d, 0);
    setd(1'b1, ins(5'd0, 5'd1, 5'd0), 32'h210, 16'h0001);
    tick;
    setd(1'b1, ins(5'd4, 5'd0, 5'd0), 32'h214, 16'h0002);
    #1;
    chk("x0_load_nostall", stall_d, 0);
    tick;
    chk("x0_load_valid", valid_e, 1);
    chk("x0_load_cnt", bub, exp_bub);
    setd(1'b1, ins(5'd9, 5'd1, 5'd2), 32'h100, 16'h0004);
    tick;
    stall_e = 1'b1;
    setd(1'b1, ins(5'd10, 5'd1, 5'd2), 32'h300, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_d_out", stall_d, 1);
      tick;
      chk("stall_pc", pc_e, 32'h100);
      chk("stall_valid", valid_e, 1);
      chk("stall_ctrl", ctrl_e, 16'h0004);
    end
    flush_e = 1'b1;
    tick;
    chk("flush_valid", valid_e, 0);
    chk("flush_ctrl", ctrl_e, 0);
    chk("flush_pc_hold", pc_e, 32'h100);
    chk("flush_cnt", bub, exp_bub);
    stall_e = 1'b0; flush_e = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      setd(1'b1, ins(5'd3, 5'd1, 5'd0), 32'h400, 16'h0001);
      tick;
      setd(1'b1, (n % 2 == 1) ? ins(5'd4, 5'd3, 5'd1) : ins(5'd4, 5'd1, 5'd3), 32'h404, 16'h0002);
      #1;
      chk("sat_stall_d", stall_d, 1);
      tick;
      exp_bub++;
      chk("sat_cnt_main", bub, exp_bub);
      chk("sat_cnt_2bit", s_bub, (exp_bub > 3) ? 3 : exp_bub);
      tick;
      chk("sat_add_valid", valid_e, 1);
    end
    chk("sat_final", s_bub, 2'b11);
    setd(1'b1, ins(5'd3, 5'd1, 5'd0), 32'h500, 16'h0001);
    tick;
    setd(1'b1, ins(5'd4, 5'd3, 5'd1), 32'h504, 16'h0002);
    rstn = 1'b0;
    tick;
    chk("midrst_valid", valid_e, 0);
    chk("midrst_pc", pc_e, 0);
    chk("midrst_stall_d", stall_d, 0);
    chk("midrst_cnt", bub, 0);
    chk("midrst_sat_cnt", s_bub, 0);
    rstn = 1'b1;
    setd(1'b1, ins(5'd6, 5'd5, 5'd0), 32'h600, 16'h0000);
    tick;
    chk("midrst_rf_cleared", rd1_e, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
